// File: rtl/port_int_narrow.sv
// Two-stage registered converter: narrows a 32-bit signed/unsigned value onto byte, byte unsigned,
// shortint and shortint unsigned lanes with per-lane out-of-range flags and a saturation counter.
module port_int_narrow #(
    parameter bit          SAT_EN = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output byte               out_b,
    output byte unsigned      out_bu,
    output shortint           out_s,
    output shortint unsigned  out_su,
    output logic [3:0]        out_flags,
    output logic [CNT_W-1:0]  sat_count
);

    localparam logic signed [32:0] BMin  = -33'sd128;
    localparam logic signed [32:0] BMax  = 33'sd127;
    localparam logic signed [32:0] BuMax = 33'sd255;
    localparam logic signed [32:0] SMin  = -33'sd32768;
    localparam logic signed [32:0] SMax  = 33'sd32767;
    localparam logic signed [32:0] SuMax = 33'sd65535;

    logic              advance;
    logic              a_valid_q, a_valid_d;
    logic [31:0]       a_data_q, a_data_d;
    logic              a_signed_q, a_signed_d;
    logic              b_valid_q, b_valid_d;
    logic [7:0]        lane_b_q, lane_b_d, lane_bu_q, lane_bu_d;
    logic [15:0]       lane_s_q, lane_s_d, lane_su_q, lane_su_d;
    logic [3:0]        flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic signed [32:0] v;
    logic              b_lo, b_hi, bu_lo, bu_hi, s_lo, s_hi, su_lo, su_hi;

    assign advance  = !b_valid_q || out_ready;
    assign in_ready = advance;

    // 33-bit view makes signed and unsigned inputs directly comparable
    assign v     = {a_signed_q & a_data_q[31], a_data_q};
    assign b_lo  = v < BMin;
    assign b_hi  = v > BMax;
    assign bu_lo = v[32];
    assign bu_hi = v > BuMax;
    assign s_lo  = v < SMin;
    assign s_hi  = v > SMax;
    assign su_lo = v[32];
    assign su_hi = v > SuMax;

    always_comb begin
        a_valid_d  = a_valid_q;
        a_data_d   = a_data_q;
        a_signed_d = a_signed_q;
        b_valid_d  = b_valid_q;
        lane_b_d   = lane_b_q;
        lane_bu_d  = lane_bu_q;
        lane_s_d   = lane_s_q;
        lane_su_d  = lane_su_q;
        flags_d    = flags_q;
        cnt_d      = cnt_q;

        if (b_valid_q && out_ready && (|flags_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (advance) begin
            a_valid_d  = in_valid;
            a_data_d   = in_data;
            a_signed_d = in_signed;
            b_valid_d  = a_valid_q;
            flags_d    = {su_lo | su_hi, s_lo | s_hi, bu_lo | bu_hi, b_lo | b_hi};
            if (SAT_EN) begin
                // In range, the low bits already equal the value
                lane_b_d  = b_lo  ? 8'h80    : (b_hi  ? 8'h7F    : a_data_q[7:0]);
                lane_bu_d = bu_lo ? 8'h00    : (bu_hi ? 8'hFF    : a_data_q[7:0]);
                lane_s_d  = s_lo  ? 16'h8000 : (s_hi  ? 16'h7FFF : a_data_q[15:0]);
                lane_su_d = su_lo ? 16'h0000 : (su_hi ? 16'hFFFF : a_data_q[15:0]);
            end else begin
                lane_b_d  = a_data_q[7:0];
                lane_bu_d = a_data_q[7:0];
                lane_s_d  = a_data_q[15:0];
                lane_su_d = a_data_q[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q  <= 1'b0;
            a_data_q   <= '0;
            a_signed_q <= 1'b0;
            b_valid_q  <= 1'b0;
            lane_b_q   <= '0;
            lane_bu_q  <= '0;
            lane_s_q   <= '0;
            lane_su_q  <= '0;
            flags_q    <= '0;
            cnt_q      <= '0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_data_q   <= a_data_d;
            a_signed_q <= a_signed_d;
            b_valid_q  <= b_valid_d;
            lane_b_q   <= lane_b_d;
            lane_bu_q  <= lane_bu_d;
            lane_s_q   <= lane_s_d;
            lane_su_q  <= lane_su_d;
            flags_q    <= flags_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = b_valid_q;
    assign out_b     = lane_b_q;
    assign out_bu    = lane_bu_q;
    assign out_s     = lane_s_q;
    assign out_su    = lane_su_q;
    assign out_flags = flags_q;
    assign sat_count = cnt_q;

endmodule
